// File: rtl/systolic_array_n.sv
// systolic_array_n: ROWS x COLS weight-stationary systolic array computing
// data_out[c] = sum_r data_in[r]*W[r][c], one vector per cycle, latency ROWS+COLS.
// Ports: clk, rst (async, active-high); data_in/data_valid_in activation vector;
//   weight_in/accept_w per-column shadow weight shift; switch_in shadow->active;
//   col_size_in/col_size_valid_in column enable count; data_out/valid_out aligned
//   results; busy (vectors in flight); w_err (sticky weight-protocol violation).
module systolic_array_n #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ROWS*DATA_W-1:0]    data_in,
    input  logic                      data_valid_in,
    input  logic [COLS*DATA_W-1:0]    weight_in,
    input  logic [COLS-1:0]           accept_w,
    input  logic                      switch_in,
    input  logic [$clog2(COLS+1)-1:0] col_size_in,
    input  logic                      col_size_valid_in,
    output logic [COLS*ACC_W-1:0]     data_out,
    output logic [COLS-1:0]           valid_out,
    output logic                      busy,
    output logic                      w_err
);
    localparam int L   = ROWS + COLS;
    localparam int CSW = $clog2(COLS + 1);
    localparam int WCW = $clog2(L + 1);

    typedef logic signed [DATA_W-1:0]   dat_t;
    typedef logic signed [2*DATA_W-1:0] prd_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    dat_t shadow_q [ROWS][COLS];
    dat_t shadow_d [ROWS][COLS];
    dat_t active_q [ROWS][COLS];
    dat_t act_q    [ROWS][COLS];
    acc_t psum_q   [ROWS][COLS];
    dat_t a_d      [ROWS][COLS];
    acc_t p_d      [ROWS][COLS];
    prd_t prod_d   [ROWS][COLS];
    dat_t skew_q   [ROWS][ROWS];
    acc_t dsk_q    [COLS][COLS];

    logic [L-1:0]     vld_q;
    logic [COLS-1:0]  msk_q [L];
    logic [COLS-1:0]  mask_q;
    logic [COLS-1:0]  mask_d;
    logic [WCW-1:0]   win_q;
    logic             w_err_q;
    logic [COLS-1:0]  vout_q;
    logic [COLS*ACC_W-1:0] dout_q;
    logic             in_win;
    logic             sw_go;

    assign data_out  = dout_q;
    assign valid_out = vout_q;
    assign busy      = |vld_q;
    assign w_err     = w_err_q;

    always_comb begin
        int rp;
        int cp;
        in_win = (win_q != '0);
        sw_go  = switch_in && !in_win;
        for (int c = 0; c < COLS; c++) begin
            mask_d[c] = (CSW'(c) < col_size_in);
        end
        for (int r = 0; r < ROWS; r++) begin
            rp = (r > 0) ? r - 1 : 0;
            for (int c = 0; c < COLS; c++) begin
                cp = (c > 0) ? c - 1 : 0;
                // Shadow column shifts down; frozen during the switch window.
                shadow_d[r][c] = shadow_q[r][c];
                if (accept_w[c] && !in_win) begin
                    if (r == 0)
                        shadow_d[r][c] = dat_t'(weight_in[c*DATA_W +: DATA_W]);
                    else
                        shadow_d[r][c] = shadow_q[rp][c];
                end
                // Activation source: skewed row input at column 0, left PE otherwise.
                if (c > 0)
                    a_d[r][c] = act_q[r][cp];
                else if (r == 0)
                    a_d[r][c] = dat_t'(data_in[DATA_W-1:0]);
                else
                    a_d[r][c] = skew_q[r][rp];
                p_d[r][c]    = (r == 0) ? '0 : psum_q[rp][c];
                prod_d[r][c] = prd_t'(a_d[r][c]) * prd_t'(active_q[r][c]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            mask_q  <= '0;
            win_q   <= '0;
            w_err_q <= 1'b0;
            vout_q  <= '0;
            dout_q  <= '0;
            for (int k = 0; k < L; k++) msk_q[k] <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < ROWS; k++) skew_q[r][k] <= '0;
                for (int c = 0; c < COLS; c++) begin
                    shadow_q[r][c] <= '0;
                    active_q[r][c] <= '0;
                    act_q[r][c]    <= '0;
                    psum_q[r][c]   <= '0;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                for (int k = 0; k < COLS; k++) dsk_q[c][k] <= '0;
            end
        end else begin
            // Valid and mask travel with the vector; mask is sampled pre-update.
            vld_q    <= {vld_q[L-2:0], data_valid_in};
            msk_q[0] <= mask_q;
            for (int k = 1; k < L; k++) msk_q[k] <= msk_q[k-1];
            if (col_size_valid_in) mask_q <= mask_d;

            // win_q counts down the switch window; it also times the wavefront.
            if (sw_go)
                win_q <= WCW'(L - 1);
            else if (in_win)
                win_q <= win_q - WCW'(1);
            if (in_win && (switch_in || (|accept_w))) w_err_q <= 1'b1;

            for (int r = 0; r < ROWS; r++) begin
                skew_q[r][0] <= dat_t'(data_in[r*DATA_W +: DATA_W]);
                for (int k = 1; k < ROWS; k++) skew_q[r][k] <= skew_q[r][k-1];
                for (int c = 0; c < COLS; c++) begin
                    shadow_q[r][c] <= shadow_d[r][c];
                    act_q[r][c]    <= a_d[r][c];
                    psum_q[r][c]   <= p_d[r][c] + acc_t'(prod_d[r][c]);
                    // PE(r,c) flips r+c edges after the switch edge, just after
                    // the last old-weight vector has passed through it.
                    if (r + c == 0) begin
                        if (sw_go) active_q[r][c] <= shadow_d[r][c];
                    end else if (win_q == WCW'(L - r - c)) begin
                        active_q[r][c] <= shadow_q[r][c];
                    end
                end
            end

            for (int c = 0; c < COLS; c++) begin
                dsk_q[c][0] <= psum_q[ROWS-1][c];
                for (int k = 1; k < COLS; k++) dsk_q[c][k] <= dsk_q[c][k-1];
                vout_q[c] <= vld_q[L-1] & msk_q[L-1][c];
                dout_q[c*ACC_W +: ACC_W] <= (vld_q[L-1] && msk_q[L-1][c])
                                            ? dsk_q[c][COLS-1-c] : '0;
            end
        end
    end
endmodule
